light_sequencer: RTL and testbench
==================================

# light_sequencer

Sequential lamp driver sitting directly downstream of the lighting system block. It takes the 16-bit `lightstate` pattern as a target and walks the physical lamp outputs toward it one lamp per step interval, so that inrush and visual flicker stay bounded. It reports busy/done status and a live count of lit lamps.

## Interface

**Parameters**
- `STEP`, default 4: clock cycles between successive lamp changes. Legal range 1..255.
- `CW`, default 8: prescaler counter width. Must satisfy 2^CW > STEP.

**Ports**
- `clk` input 1: single system clock, rising edge.
- `rstn` input 1: asynchronous, active-low reset.
- `lightstate` input 16: target lamp pattern from the lighting system; bit i = lamp i on.
- `load` input 1: sampled on a rising edge; latches `lightstate` as the new target.
- `lamp` output 16: registered lamp drive.
- `busy` output 1: high while in RAMP.
- `done` output 1: single-cycle pulse when `lamp` reaches the target.
- `onnum` output 5: popcount of `lamp`, 0..16, combinational from the `lamp` register.

## Operation

- **Reset values:**
  - `lamp` = 0, target = 0, prescaler = 0.
  - `busy` = 0, `done` = 0, `onnum` = 0.
  - State = IDLE.
- **States:** IDLE, RAMP, DONE. `busy` = (state == RAMP). `done` = (state == DONE).
- **IDLE or DONE with `load` = 1:** target ← `lightstate`, prescaler ← 0, state → RAMP. DONE always leaves after one cycle: to RAMP if `load` is high, otherwise to IDLE.
- **RAMP, evaluated each edge in priority order:**
  1. If `load` = 1, target ← `lightstate`. This is a retarget. The prescaler is not restarted, and the comparison below uses the old target for this edge.
  2. If `lamp` == target, state → DONE and prescaler ← 0.
  3. Else if prescaler == STEP−1, toggle exactly one lamp and set prescaler ← 0. The lamp toggled is the lowest-index bit where `lamp` ≠ target.
  4. Else prescaler ← prescaler + 1.
- Exactly one lamp bit changes per toggle. Both turn-on and turn-off move toward the target. No wrap-around is possible because the prescaler always clears at STEP−1.
- `onnum` tracks `lamp` with no latency.
- **Reset mid-operation:** all state clears immediately and asynchronously, and all lamps go off. Deasserting `rstn` returns the block to IDLE.

## Timing

- Load accepted at edge L. The first toggle happens at edge L+STEP, and toggle n happens at edge L+n·STEP.
- After the last toggle at edge T, equality is detected at edge T+1. `done` is high for the single cycle following edge T+1, and `busy` falls at edge T+1.
- **Load with target already equal to `lamp`:** RAMP for one cycle, then `done` is high for one cycle (DONE entered at L+1).
- **Worst case:** 16 toggles, giving 16·STEP+1 cycles from load to DONE.
- **STEP = 1:** one toggle per cycle.

## Structure

- **Shared package `light_pkg`:**
  - State encoding constants `S_IDLE` = 2'd0, `S_RAMP` = 2'd1, `S_DONE` = 2'd2.
  - `NLAMP` = 16.
- **Sub-module `lsb_diff`:** 16-bit priority encoder that returns a one-hot mask of the lowest set bit of `lamp ^ target`. The toggle is `lamp ^ mask`.
- The popcount for `onnum` stays inline in the top level.

## Test plan

1. **Reset:** assert `rstn` = 0 at any time. Expect `lamp` = 0, `busy` = 0, `done` = 0, `onnum` = 0 immediately, without waiting for a clock edge.
2. **Ramp up:** STEP = 4, `lamp` = 0, `load` with `lightstate` = 16'h000F at edge L.
   - `lamp` = 0001, 0003, 0007, 000F at edges L+4, L+8, L+12, L+16.
   - `done` high for the cycle after edge L+17.
   - `onnum` = 4.
3. **Ramp down:** from 000F, `load` 16'h0005. Expect `lamp` = 000D at L+4, 0005 at L+8, then `done`; `onnum` = 2.
4. **Retarget:** from 0, load 16'h00FF. After the 2nd toggle (`lamp` = 0003), load 16'h0001 one cycle later.
   - Next toggle clears bit 1, giving `lamp` = 0001.
   - Toggle spacing stays 4 cycles.
   - Then `done`.
5. **Equal target:** `lamp` = 0005, load 16'h0005. Expect `busy` high for one cycle, `done` the next cycle, `lamp` unchanged.
6. **Reset mid-ramp:** during scenario 2, drop `rstn` at L+9.
   - `lamp` = 0 and state IDLE immediately.
   - After release, no toggles occur until the next `load`.

Source files
------------

// File: rtl/light_pkg.sv
// Shared definitions for the lamp sequencer: FSM state encoding and lamp count.
package light_pkg;

  localparam int NLAMP = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RAMP = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/light_sequencer_if.sv
// Target/status bundle between the lighting system (master) and the lamp sequencer (slave).
interface light_sequencer_if;
  import light_pkg::*;

  logic [NLAMP-1:0] lightstate;
  logic             load;
  logic [NLAMP-1:0] lamp;
  logic             busy;
  logic             done;
  logic [4:0]       onnum;

  modport master (
    output lightstate, load,
    input  lamp, busy, done, onnum
  );

  modport slave (
    input  lightstate, load,
    output lamp, busy, done, onnum
  );

endinterface

// File: rtl/light_sequencer_lsb_diff.sv
// Priority encoder: one-hot mask of the lowest-index lamp that differs from the target.
module lsb_diff
  import light_pkg::*;
(
  input  logic [NLAMP-1:0] lamp,
  input  logic [NLAMP-1:0] target,
  output logic [NLAMP-1:0] mask
);

  logic [NLAMP-1:0] diff;
  logic [NLAMP-1:0] seen;

  assign diff    = lamp ^ target;
  assign seen[0] = 1'b0;

  // seen[i] is high when any lower bit already differs
  generate
    for (genvar gi = 1; gi < NLAMP; gi++) begin : g_seen
      assign seen[gi] = seen[gi-1] | diff[gi-1];
    end
    for (genvar gi = 0; gi < NLAMP; gi++) begin : g_mask
      assign mask[gi] = diff[gi] & ~seen[gi];
    end
  endgenerate

endmodule

// File: rtl/light_sequencer.sv
// Walks the lamp outputs toward a latched target one lamp per STEP cycles,
// with busy/done status and a live popcount of lit lamps.
module light_sequencer
  import light_pkg::*;
#(
  parameter int STEP = 4,
  parameter int CW   = 8
)
(
  input  logic             clk,
  input  logic             rstn,
  light_sequencer_if.slave bus
);

  localparam logic [CW-1:0] PRESC_LAST = CW'(STEP - 1);

  state_t           state_reg, state_next;
  logic [NLAMP-1:0] lamp_reg, lamp_next;
  logic [NLAMP-1:0] target_reg, target_next;
  logic [CW-1:0]    presc_reg, presc_next;
  logic [NLAMP-1:0] toggle_mask;
  logic [4:0]       onnum_comb;

  lsb_diff u_lsb_diff (
    .lamp   (lamp_reg),
    .target (target_reg),
    .mask   (toggle_mask)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg  <= S_IDLE;
      lamp_reg   <= '0;
      target_reg <= '0;
      presc_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      lamp_reg   <= lamp_next;
      target_reg <= target_next;
      presc_reg  <= presc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    lamp_next   = lamp_reg;
    target_next = target_reg;
    presc_next  = presc_reg;
    case (state_reg)
      S_IDLE, S_DONE: begin
        if (bus.load) begin
          target_next = bus.lightstate;
          presc_next  = '0;
          state_next  = S_RAMP;
        end else begin
          state_next  = S_IDLE;
        end
      end
      S_RAMP: begin
        // A retarget only takes effect next edge; this edge still compares against the old target.
        if (bus.load) begin
          target_next = bus.lightstate;
        end
        if (lamp_reg == target_reg) begin
          state_next = S_DONE;
          presc_next = '0;
        end else if (presc_reg == PRESC_LAST) begin
          lamp_next  = lamp_reg ^ toggle_mask;
          presc_next = '0;
        end else begin
          presc_next = presc_reg + 1'b1;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    onnum_comb = '0;
    for (int i = 0; i < NLAMP; i++) begin
      onnum_comb = onnum_comb + 5'(lamp_reg[i]);
    end
  end

  assign bus.lamp  = lamp_reg;
  assign bus.busy  = (state_reg == S_RAMP);
  assign bus.done  = (state_reg == S_DONE);
  assign bus.onnum = onnum_comb;

endmodule

// File: tb/tb_light_sequencer.sv
// Directed bench for light_sequencer with STEP=4: reset, ramp up/down, retarget,
// equal target, reload from DONE, and reset mid-ramp.
module tb_light_sequencer;

  logic clk;
  logic rstn;
  int   vectors;
  int   miscompares;

  light_sequencer_if bus ();

  light_sequencer #(.STEP(4), .CW(8)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [15:0] lamp_exp,
                         input logic busy_exp, input logic done_exp, input logic [4:0] onnum_exp);
    $display("%s: lamp=%h busy=%b done=%b onnum=%0d", tag, bus.lamp, bus.busy, bus.done, bus.onnum);
    chk({tag, ".lamp"},  bus.lamp, lamp_exp);
    chk({tag, ".busy"},  16'(bus.busy), 16'(busy_exp));
    chk({tag, ".done"},  16'(bus.done), 16'(done_exp));
    chk({tag, ".onnum"}, 16'(bus.onnum), 16'(onnum_exp));
  endtask

  // Accept a load on the next edge (L), leaving load low afterwards.
  task automatic do_load(input logic [15:0] pat);
    bus.lightstate = pat;
    bus.load       = 1'b1;
    tick();
    bus.load       = 1'b0;
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    rstn           = 1'b1;
    bus.load       = 1'b0;
    bus.lightstate = 16'h0000;

    // Asynchronous reset, checked before the first clock edge
    #2 rstn = 1'b0;
    #1 chk_all("reset", 16'h0000, 1'b0, 1'b0, 5'd0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    chk_all("idle_after_reset", 16'h0000, 1'b0, 1'b0, 5'd0);

    // Ramp up 0000 -> 000F
    do_load(16'h000F);
    chk_all("up_L", 16'h0000, 1'b1, 1'b0, 5'd0);
    repeat (3) tick();
    chk_all("up_L3", 16'h0000, 1'b1, 1'b0, 5'd0);
    tick(); chk_all("up_L4",  16'h0001, 1'b1, 1'b0, 5'd1);
    repeat (4) tick(); chk_all("up_L8",  16'h0003, 1'b1, 1'b0, 5'd2);
    repeat (4) tick(); chk_all("up_L12", 16'h0007, 1'b1, 1'b0, 5'd3);
    repeat (4) tick(); chk_all("up_L16", 16'h000F, 1'b1, 1'b0, 5'd4);
    tick(); chk_all("up_L17_done", 16'h000F, 1'b0, 1'b1, 5'd4);
    tick(); chk_all("up_L18_idle", 16'h000F, 1'b0, 1'b0, 5'd4);

    // Ramp down 000F -> 0005
    do_load(16'h0005);
    repeat (4) tick(); chk_all("down_L4", 16'h000D, 1'b1, 1'b0, 5'd3);
    repeat (4) tick(); chk_all("down_L8", 16'h0005, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("down_done", 16'h0005, 1'b0, 1'b1, 5'd2);
    tick();

    // Clear to 0000 (lowest differing bit goes first)
    do_load(16'h0000);
    repeat (4) tick(); chk_all("clr_L4", 16'h0004, 1'b1, 1'b0, 5'd1);
    repeat (4) tick(); chk_all("clr_L8", 16'h0000, 1'b1, 1'b0, 5'd0);
    tick(); chk_all("clr_done", 16'h0000, 1'b0, 1'b1, 5'd0);
    tick();

    // Retarget: 00FF, then 0001 one cycle after the second toggle
    do_load(16'h00FF);
    repeat (4) tick(); chk_all("rt_L4", 16'h0001, 1'b1, 1'b0, 5'd1);
    repeat (4) tick(); chk_all("rt_L8", 16'h0003, 1'b1, 1'b0, 5'd2);
    do_load(16'h0001);
    chk_all("rt_L9", 16'h0003, 1'b1, 1'b0, 5'd2);
    repeat (2) tick(); chk_all("rt_L11", 16'h0003, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("rt_L12", 16'h0001, 1'b1, 1'b0, 5'd1);
    tick(); chk_all("rt_done", 16'h0001, 1'b0, 1'b1, 5'd1);
    tick();

    // Bring lamp to 0005, then load an equal target
    do_load(16'h0005);
    repeat (4) tick(); chk_all("pre_eq_L4", 16'h0005, 1'b1, 1'b0, 5'd2);
    tick();
    tick();
    do_load(16'h0005);
    chk_all("eq_L", 16'h0005, 1'b1, 1'b0, 5'd2);
    tick(); chk_all("eq_L1_done", 16'h0005, 1'b0, 1'b1, 5'd2);

    // Load while in DONE goes straight back to RAMP
    do_load(16'h0004);
    chk_all("done_reload", 16'h0005, 1'b1, 1'b0, 5'd2);
    repeat (4) tick(); chk_all("done_reload_L4", 16'h0004, 1'b1, 1'b0, 5'd1);
    tick(); chk_all("done_reload_done", 16'h0004, 1'b0, 1'b1, 5'd1);
    tick();

    // Reset mid-ramp
    rstn = 1'b0;
    #1 chk_all("rst_pre", 16'h0000, 1'b0, 1'b0, 5'd0);
    tick();
    rstn = 1'b1;
    do_load(16'h000F);
    repeat (8) tick(); chk_all("mid_L8", 16'h0003, 1'b1, 1'b0, 5'd2);
    tick();
    rstn = 1'b0;
    #1 chk_all("mid_rst", 16'h0000, 1'b0, 1'b0, 5'd0);
    tick();
    rstn = 1'b1;
    repeat (20) tick();
    chk_all("mid_after_release", 16'h0000, 1'b0, 1'b0, 5'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
